// File: rtl/mem_wait_slave.sv
// Word-addressed memory slave with configurable wait states on a read/write/waitrequest bus.
// Out-of-range accesses raise a sticky error; address zero reads as zero and silently drops writes.
module mem_wait_slave #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned DEPTH       = 64,
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        err,
    input  logic        load_en,
    input  logic [9:0]  load_addr,
    input  logic [31:0] load_data
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [3:0]  CNT_INIT = 4'(WAIT_CYCLES - 1);
    localparam logic [31:0] SPAN     = 32'(4 * DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ACK
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [3:0]     cnt;
    logic [3:0]     cnt_nx;
    logic           access;
    logic           req;
    logic [31:0]    offset;
    logic           in_range;
    logic           zero_addr;
    logic [AW-1:0]  word_idx;
    logic [3:0]     be_eff;
    logic [31:0]    wr_word;
    logic           mem_wr;
    logic           rd_cap;
    logic           err_set;

    logic [31:0]    mem [DEPTH];

    assign req         = read | write;
    assign waitrequest = req && (state != ACK);

    // Unsigned wrap folds the lower-bound test into a single compare.
    assign offset    = address - BASE_ADDR;
    assign in_range  = offset < SPAN;
    assign zero_addr = (address == '0);
    assign word_idx  = offset[AW+1:2];
    assign be_eff    = (byteenable == '0) ? '1 : byteenable;

    always_comb begin
        wr_word = mem[word_idx];
        for (int unsigned i = 0; i < 4; i++) begin
            if (be_eff[i]) begin
                wr_word[8*i +: 8] = writedata[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        access   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nx = ACK;
                        access   = 1'b1;
                    end else begin
                        state_nx = BUSY;
                        cnt_nx   = CNT_INIT;
                    end
                end
            end
            BUSY: begin
                if (!req) begin
                    state_nx = IDLE;
                end else if (cnt == '0) begin
                    state_nx = ACK;
                    access   = 1'b1;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign mem_wr  = access && write && !zero_addr && in_range && !reset;
    assign rd_cap  = access && read && !write;
    assign err_set = access && !zero_addr && (!in_range || (read && write));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            readdata <= '0;
            err      <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (rd_cap) begin
                readdata <= (!zero_addr && in_range) ? mem[word_idx] : '0;
            end
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

    // Bus write is assigned after the preload so it wins on a same-edge collision.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr[AW-1:0]] <= load_data;
        end
        if (mem_wr) begin
            mem[word_idx] <= wr_word;
        end
    end

endmodule

// File: doc/mem_wait_slave.md
MEM_WAIT_SLAVE -- requirements
Module: mem_wait_slave

Interface
REQ-001 Parameter: WAIT_CYCLES, default 2, extra wait-state cycles inserted per bus transfer (0..15).
REQ-002 Parameter: DEPTH, default 64, memory depth in 32-bit words (power of two, 4..1024).
REQ-003 Parameter: BASE_ADDR, default 32'hBFC00000, byte address mapped to word 0.
REQ-004 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-high reset.
REQ-006 Port: address  input  32  byte address from the CPU bus master.
REQ-007 Port: read  input  1  read request, held until waitrequest is low.
REQ-008 Port: write  input  1  write request, held until waitrequest is low.
REQ-009 Port: writedata  input  32  write data, lane-aligned.
REQ-010 Port: byteenable  input  4  byte-lane enables; bit n selects writedata[8n+7:8n].
REQ-011 Port: waitrequest  output  1  stall to master; low marks transfer completion.
REQ-012 Port: readdata  output  32  registered read data.
REQ-013 Port: err  output  1  sticky error flag.
REQ-014 Port: load_en  input  1  bench preload strobe.
REQ-015 Port: load_addr  input  10  preload word index.
REQ-016 Port: load_data  input  32  preload word.

Function
REQ-017 FSM states IDLE, BUSY, ACK; 4-bit down-counter cnt.
REQ-018 waitrequest SHALL be combinational: (read|write) && state!=ACK.
REQ-019 IDLE with read|write: WAIT_CYCLES>0 -> BUSY, cnt=WAIT_CYCLES-1; WAIT_CYCLES=0 -> ACK directly.
REQ-020 BUSY: cnt!=0 -> decrement; cnt==0 -> ACK; memory access and readdata capture occur on this transition edge.
REQ-021 ACK: waitrequest low for exactly one cycle; next state IDLE unconditionally.
REQ-022 Transfer latency: waitrequest high for WAIT_CYCLES+1 cycles, then low one cycle with readdata valid.
REQ-023 Word index = (address-BASE_ADDR)>>2; address[1:0] ignored.
REQ-024 In range: BASE_ADDR <= address < BASE_ADDR+4*DEPTH; otherwise out-of-range.
REQ-025 Out-of-range read: readdata=0, err set; out-of-range write: dropped, err set.
REQ-026 address==0: read returns 0, write dropped, err NOT set, same wait timing.
REQ-027 Write updates only lanes with byteenable bit set; byteenable 4'b0000 SHALL be treated as 4'b1111.
REQ-028 read&write both high at request: treated as write, readdata unchanged, err set.
REQ-029 Master drops read|write while in BUSY: abort to IDLE, no memory update, readdata unchanged.
REQ-030 Write then read of the same word in consecutive transfers: read returns new data.
REQ-031 load_en: mem[load_addr mod DEPTH]<=load_data at the edge, any state; same-edge bus write to same word wins.
REQ-032 readdata holds its value between reads.
REQ-033 err clears only on reset.

Reset
REQ-034 reset high: state=IDLE, cnt=0, readdata=0, err=0 immediately, independent of clk.
REQ-035 Memory contents SHALL NOT be cleared by reset; reset mid-transfer abandons the transfer with no memory update.
REQ-036 Outputs after reset: waitrequest follows REQ-018 (state IDLE), readdata=0, err=0.

Verification
REQ-037 Preload word 11=32'd2, WAIT_CYCLES=2; read 0xBFC0002C -> waitrequest high 3 cycles, then low 1 cycle with readdata=32'h00000002.
REQ-038 Write 0xBFC00030 data 32'hAABBCCDD byteenable 4'b0010, prior word 0 -> subsequent read returns 32'h0000CC00.
REQ-039 Read 0x00000000 -> readdata=0, err=0; read 0xBFC00100 with DEPTH=64 -> readdata=0, err=1 until reset.
REQ-040 Deassert read after 1 BUSY cycle -> state IDLE, readdata unchanged; assert reset during BUSY write -> readdata=0, target word unchanged.
REQ-041 WAIT_CYCLES=0, back-to-back write 32'h12345678 then read same word -> each waitrequest high 1 cycle, read returns 32'h12345678.
